// File: rtl/exhaustive_vector_sweeper_if.sv
// exhaustive_vector_sweeper_if: sweep control, DUT drive/sample and response stream
// master = sweeper, slave = controller/DUT/logger side.
interface exhaustive_vector_sweeper_if #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 1,
   parameter int SIG_W = 16
);
   logic             start;
   logic             busy;
   logic             done;
   logic [N_IN-1:0]  vec_out;
   logic             vec_valid;
   logic [N_OUT-1:0] dut_resp;
   logic             resp_valid;
   logic             resp_ready;
   logic [N_IN-1:0]  resp_vec;
   logic [N_OUT-1:0] resp_data;
   logic [SIG_W-1:0] signature;
   logic [N_IN:0]    ones_count;
   modport master (
      input  start, dut_resp, resp_ready,
      output busy, done, vec_out, vec_valid, resp_valid, resp_vec, resp_data, signature, ones_count
   );
   modport slave (
      output start, dut_resp, resp_ready,
      input  busy, done, vec_out, vec_valid, resp_valid, resp_vec, resp_data, signature, ones_count
   );
endinterface

// File: rtl/exhaustive_vector_sweeper.sv
// exhaustive_vector_sweeper: applies every N_IN-bit vector, samples the response, streams pairs and a MISR.
// Define SWEEP_GRAY_EN to sweep in Gray order instead of binary order.
module exhaustive_vector_sweeper #(
   parameter int               N_IN     = 4,
   parameter int               N_OUT    = 1,
   parameter int               SETTLE   = 1,
   parameter int               SIG_W    = 16,
   parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
   parameter logic [SIG_W-1:0] SIG_SEED = 16'hFFFF
) (
   input logic                         CK,
   input logic                         reset,
   exhaustive_vector_sweeper_if.master bus
);
   localparam int            CW   = $clog2(SETTLE + 1) + 1;
   localparam logic [N_IN:0] LAST = (N_IN + 1)'((1 << N_IN) - 1);
   typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CAPTURE, S_EMIT, S_DONE} state_t;
   state_t           state, state_n;
   logic [N_IN:0]    idx;
   logic [CW-1:0]    cnt;
   logic [N_IN-1:0]  vec;
   logic [N_IN-1:0]  rvec;
   logic [N_OUT-1:0] rdata;
   logic [SIG_W-1:0] sig, misr_n;
   logic [N_IN:0]    ones;
   logic             go, ack, last, idle;
   function automatic logic [N_IN-1:0] order(input logic [N_IN:0] i);
`ifdef SWEEP_GRAY_EN
      return N_IN'(i ^ (i >> 1));
`else
      return N_IN'(i);
`endif
   endfunction
   assign idle   = state == S_IDLE || state == S_DONE;
   assign go     = idle && bus.start;
   assign ack    = state == S_EMIT && bus.resp_ready;
   assign last   = idx == LAST;
   assign misr_n = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : '0) ^ SIG_W'(bus.dut_resp);
   always_ff @(posedge CK or negedge reset)
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE, S_DONE: state_n = bus.start ? S_APPLY : state;
         S_APPLY:        state_n = SETTLE > 0 ? S_SETTLE : S_CAPTURE;
         S_SETTLE:       state_n = cnt == CW'(1) ? S_CAPTURE : S_SETTLE;
         S_CAPTURE:      state_n = S_EMIT;
         S_EMIT:         state_n = !bus.resp_ready ? S_EMIT : last ? S_DONE : S_APPLY;
         default:        state_n = S_IDLE;
      endcase
   end
   // vec is loaded on the way into APPLY so it is already valid during APPLY
   always_ff @(posedge CK or negedge reset) begin
      if (!reset) begin
         idx   <= '0;
         cnt   <= '0;
         vec   <= '0;
         rvec  <= '0;
         rdata <= '0;
         sig   <= '0;
         ones  <= '0;
      end else begin
         if (go) begin
            idx  <= '0;
            vec  <= order('0);
            sig  <= SIG_SEED;
            ones <= '0;
         end
         if (state == S_APPLY) cnt <= CW'(SETTLE);
         if (state == S_SETTLE) cnt <= cnt - CW'(1);
         if (state == S_CAPTURE) begin
            rdata <= bus.dut_resp;
            rvec  <= vec;
            sig   <= misr_n;
            ones  <= ones + (N_IN + 1)'(|bus.dut_resp);
         end
         if (ack && !last) begin
            idx <= idx + (N_IN + 1)'(1);
            vec <= order(idx + (N_IN + 1)'(1));
         end
      end
   end
   assign bus.busy       = !idle;
   assign bus.done       = state == S_DONE;
   assign bus.vec_out    = vec;
   assign bus.vec_valid  = !idle;
   assign bus.resp_valid = state == S_EMIT;
   assign bus.resp_vec   = rvec;
   assign bus.resp_data  = rdata;
   assign bus.signature  = sig;
   assign bus.ones_count = ones;
endmodule

// File: tb/tb_exhaustive_vector_sweeper.sv
// tb_exhaustive_vector_sweeper: directed scenarios for a 4-bit, SETTLE=1 sweeper.
module tb_exhaustive_vector_sweeper;
   localparam int PER = 3 + 1;
   logic CK = 1'b0;
   logic reset = 1'b1;
   bit   mode = 1'b0;
   int   tests = 0;
   int   fails = 0;
   logic [3:0] got_vec [16];
   logic       got_data [16];
   int         got_cyc [16];
   int         n_pairs, done_cyc;
   logic       busy0, done0;
   exhaustive_vector_sweeper_if #(.N_IN(4), .N_OUT(1), .SIG_W(16)) bus ();
   exhaustive_vector_sweeper #(.N_IN(4), .N_OUT(1), .SETTLE(1), .SIG_W(16)) dut (
      .CK(CK), .reset(reset), .bus(bus)
   );
   always #5 CK = ~CK;
   assign bus.dut_resp = mode ? ^bus.vec_out : &bus.vec_out;
   function automatic logic [3:0] exp_vec(input int i);
      logic [3:0] b = i[3:0];
`ifdef SWEEP_GRAY_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction
   function automatic logic [15:0] misr_model(input bit m);
      logic [15:0] s = 16'hFFFF;
      logic [3:0]  v;
      for (int i = 0; i < 16; i++) begin
         v = exp_vec(i);
         s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, m ? ^v : &v};
      end
      return s;
   endfunction
   function automatic logic [33:0] outs();
      return {bus.busy, bus.done, bus.vec_valid, bus.resp_valid, bus.vec_out, bus.resp_vec,
              bus.resp_data, bus.signature, bus.ones_count};
   endfunction
   task automatic pulse_start();
      @(negedge CK) bus.start = 1'b1;
      @(negedge CK) bus.start = 1'b0;
   endtask
   task automatic wait_done();
      int n = 0;
      while (!bus.done && n < 400) begin
         @(negedge CK);
         n++;
      end
      tests++;
      if (!bus.done) begin
         fails++;
         $display("FAIL wait_done done=%b required 1 after %0d cycles", bus.done, n);
      end
   endtask
   task automatic run_sweep(input bit m, input int poke);
      bit poked = 1'b0;
      int cyc = 0;
      mode = m;
      bus.resp_ready = 1'b1;
      n_pairs = 0;
      done_cyc = -1;
      pulse_start();
      busy0 = bus.busy;
      done0 = bus.done;
      while (done_cyc < 0 && cyc < 400) begin
         if (bus.resp_valid) begin
            if (n_pairs < 16) begin
               got_vec[n_pairs]  = bus.resp_vec;
               got_data[n_pairs] = bus.resp_data[0];
               got_cyc[n_pairs]  = cyc;
            end
            n_pairs++;
         end
         if (bus.done) done_cyc = cyc;
         if (poke >= 0 && !poked && bus.vec_valid && bus.vec_out == 4'(poke)) begin
            bus.start = 1'b1;
            poked = 1'b1;
         end
         @(negedge CK) bus.start = 1'b0;
         cyc++;
      end
   endtask
   task automatic test_reset();
      reset = 1'b0;
      #3;
      tests++;
      if (outs() !== '0) begin
         fails++;
         $display("FAIL reset_async outputs=%h required 0", outs());
      end
      @(negedge CK) reset = 1'b1;
      @(negedge CK);
      tests++;
      if (outs() !== '0) begin
         fails++;
         $display("FAIL reset_idle outputs=%h required 0", outs());
      end
   endtask
   task automatic test_sweep_and();
      int bad_v = 0, bad_d = 0, bad_c = 0;
      run_sweep(1'b0, -1);
      tests++;
      if ({busy0, done0} !== 2'b10) begin
         fails++;
         $display("FAIL and_start busy/done=%b required 10", {busy0, done0});
      end
      tests++;
      if (n_pairs != 16) begin
         fails++;
         $display("FAIL and_pairs got %0d required 16", n_pairs);
      end
      for (int k = 0; k < 16; k++) begin
         if (got_vec[k] !== exp_vec(k)) bad_v++;
         if (got_data[k] !== &exp_vec(k)) bad_d++;
         if (got_cyc[k] != 3 + k * PER) bad_c++;
      end
      tests++;
      if (bad_v != 0) begin
         fails++;
         $display("FAIL and_order %0d vectors wrong, vec[1]=%h required %h", bad_v, got_vec[1], exp_vec(1));
      end
      tests++;
      if (bad_d != 0) begin
         fails++;
         $display("FAIL and_data %0d responses wrong, data[15]=%b required 1", bad_d, got_data[15]);
      end
      tests++;
      if (bad_c != 0) begin
         fails++;
         $display("FAIL and_latency %0d pulses mistimed, cyc[1]=%0d required %0d", bad_c, got_cyc[1], 3 + PER);
      end
      tests++;
      if (done_cyc != 16 * PER) begin
         fails++;
         $display("FAIL and_total done at cycle %0d required %0d", done_cyc, 16 * PER);
      end
      tests++;
      if ({bus.done, bus.busy, bus.vec_valid, bus.resp_valid, bus.vec_out} !== {4'b1000, exp_vec(15)}) begin
         fails++;
         $display("FAIL and_done_flags got %b required %b", {bus.done, bus.busy, bus.vec_valid, bus.resp_valid, bus.vec_out}, {4'b1000, exp_vec(15)});
      end
      tests++;
      if (bus.ones_count !== 5'd1) begin
         fails++;
         $display("FAIL and_ones got %0d required 1", bus.ones_count);
      end
      tests++;
      if (bus.signature !== misr_model(1'b0)) begin
         fails++;
         $display("FAIL and_signature got %h required %h", bus.signature, misr_model(1'b0));
      end
   endtask
   task automatic test_stall();
      int n = 0, bad = 0;
      logic [3:0] nxt;
`ifdef SWEEP_GRAY_EN
      nxt = 4'b0010;
`else
      nxt = 4'b0100;
`endif
      mode = 1'b0;
      bus.resp_ready = 1'b1;
      pulse_start();
      while (!(bus.resp_valid && bus.resp_vec == 4'b0011) && n < 200) begin
         @(negedge CK);
         n++;
      end
      tests++;
      if (n >= 200) begin
         fails++;
         $display("FAIL stall_reach resp_vec=%h required 3", bus.resp_vec);
      end
      bus.resp_ready = 1'b0;
      repeat (5) begin
         @(negedge CK);
         if ({bus.resp_valid, bus.resp_vec, bus.resp_data, bus.vec_out} !== {1'b1, 4'b0011, 1'b0, 4'b0011}) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL stall_hold %0d cycles changed, valid/vec/data/out=%b required 1_0011_0_0011", bad, {bus.resp_valid, bus.resp_vec, bus.resp_data, bus.vec_out});
      end
      bus.resp_ready = 1'b1;
      @(negedge CK);
      tests++;
      if ({bus.resp_valid, bus.vec_out} !== {1'b0, nxt}) begin
         fails++;
         $display("FAIL stall_release valid/vec_out=%b required %b", {bus.resp_valid, bus.vec_out}, {1'b0, nxt});
      end
      wait_done();
      tests++;
      if (bus.ones_count !== 5'd1) begin
         fails++;
         $display("FAIL stall_ones got %0d required 1", bus.ones_count);
      end
   endtask
   task automatic test_reset_mid();
      int n = 0, bad = 0;
      mode = 1'b0;
      bus.resp_ready = 1'b1;
      pulse_start();
      while (!(bus.vec_valid && bus.vec_out == 4'd7 && !bus.resp_valid) && n < 200) begin
         @(negedge CK);
         n++;
      end
      @(negedge CK);
      #2 reset = 1'b0;
      #1;
      tests++;
      if (outs() !== '0 || n >= 200) begin
         fails++;
         $display("FAIL reset_mid outputs=%h required 0 (search %0d cycles)", outs(), n);
      end
      @(negedge CK) reset = 1'b1;
      repeat (3) begin
         @(negedge CK);
         if (bus.resp_valid || bus.busy || bus.done) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL reset_no_pair %0d cycles active, required 0", bad);
      end
      pulse_start();
      tests++;
      if ({bus.vec_valid, bus.vec_out, bus.signature, bus.ones_count} !== {1'b1, exp_vec(0), 16'hFFFF, 5'd0}) begin
         fails++;
         $display("FAIL reset_restart valid/vec/sig/ones=%h required %h", {bus.vec_valid, bus.vec_out, bus.signature, bus.ones_count}, {1'b1, exp_vec(0), 16'hFFFF, 5'd0});
      end
      wait_done();
      tests++;
      if (bus.signature !== misr_model(1'b0)) begin
         fails++;
         $display("FAIL reset_resweep_sig got %h required %h", bus.signature, misr_model(1'b0));
      end
   endtask
   task automatic test_start_ignored();
      int bad = 0;
      run_sweep(1'b0, 5);
      for (int k = 0; k < 16; k++) if (got_vec[k] !== exp_vec(k)) bad++;
      tests++;
      if (n_pairs != 16 || bad != 0) begin
         fails++;
         $display("FAIL ignore_pairs got %0d pairs (%0d misordered) required 16", n_pairs, bad);
      end
      tests++;
      if (done_cyc != 16 * PER) begin
         fails++;
         $display("FAIL ignore_total done at cycle %0d required %0d", done_cyc, 16 * PER);
      end
      tests++;
      if (bus.signature !== misr_model(1'b0)) begin
         fails++;
         $display("FAIL ignore_signature got %h required %h", bus.signature, misr_model(1'b0));
      end
   endtask
   task automatic test_xor();
      int bad = 0;
      run_sweep(1'b1, -1);
      for (int k = 0; k < 16; k++) if (got_data[k] !== ^exp_vec(k)) bad++;
      tests++;
      if (bad != 0 || n_pairs != 16) begin
         fails++;
         $display("FAIL xor_data %0d wrong of %0d pairs, required 0 of 16", bad, n_pairs);
      end
      tests++;
      if (bus.ones_count !== 5'd8) begin
         fails++;
         $display("FAIL xor_ones got %0d required 8", bus.ones_count);
      end
      tests++;
      if (bus.signature !== misr_model(1'b1)) begin
         fails++;
         $display("FAIL xor_signature got %h required %h", bus.signature, misr_model(1'b1));
      end
   endtask
   initial begin
      bus.start = 1'b0;
      bus.resp_ready = 1'b0;
      #2;
      test_reset();
      test_sweep_and();
      test_stall();
      test_reset_mid();
      test_start_ignored();
      test_xor();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
